// File: rtl/icache_dual_fetch_responder.sv
// Dual-port direct-mapped instruction cache responder for the warp fetch arbiter's two grants,
// with a blocking single-line refill FSM. Optional flush port enabled by `define ICACHE_FLUSH_EN.

module icache_slot_lookup #(
    parameter int NUM_WARP = 8,
    parameter int WID_W    = 3
) (
    input  logic [NUM_WARP-1:0]    grant,
    input  logic [NUM_WARP*32-1:0] warp_pc,
    output logic [WID_W-1:0]       wid,
    output logic [31:0]            pc,
    output logic                   active
);
    // Grant is one-hot or zero, so OR-reducing the selected terms is an exact mux.
    always_comb begin
        wid = '0;
        pc  = '0;
        for (int w = 0; w < NUM_WARP; w++) begin
            if (grant[w]) begin
                wid = wid | WID_W'(w);
                pc  = pc | warp_pc[32*w +: 32];
            end
        end
    end

    assign active = |grant;
endmodule

module icache_dual_fetch_responder #(
    parameter int NUM_WARP   = 8,
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4,
    parameter int WID_W      = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef ICACHE_FLUSH_EN
    input  logic                     Icache_Flush,
`endif
    input  logic [NUM_WARP-1:0]      Grant1,
    input  logic [NUM_WARP-1:0]      Grant2,
    input  logic [NUM_WARP*32-1:0]   Warp_PC,
    output logic                     Rsp1_Valid,
    output logic                     Rsp1_Hit,
    output logic [WID_W-1:0]         Rsp1_Wid,
    output logic [31:0]              Rsp1_Instr,
    output logic                     Rsp2_Valid,
    output logic                     Rsp2_Hit,
    output logic [WID_W-1:0]         Rsp2_Wid,
    output logic [31:0]              Rsp2_Instr,
    output logic                     Icache_Busy,
    output logic                     Mem_Req_Valid,
    output logic [31:0]              Mem_Req_Addr,
    input  logic                     Mem_Req_Ready,
    input  logic                     Mem_Rsp_Valid,
    input  logic [LINE_WORDS*32-1:0] Mem_Rsp_Data
);
    localparam int OB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(NUM_LINES);
    localparam int TW = 32 - 2 - OB - IB;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL} state_t;
    state_t state, state_d;

    logic [NUM_LINES-1:0]             valid_q;
    logic [TW-1:0]                    tag_q  [NUM_LINES];
    logic [LINE_WORDS-1:0][31:0]      data_q [NUM_LINES];
    logic [LINE_WORDS-1:0][31:0]      fill_data;
    logic [31:0]                      line_addr_q;

    logic [1:0][NUM_WARP-1:0] grant;
    logic [1:0]               active, hit, miss;
    logic [1:0][WID_W-1:0]    wid;
    logic [1:0][31:0]         pc, instr;
    logic [1:0][IB-1:0]       idx;
    logic [1:0][OB-1:0]       off;
    logic [1:0][TW-1:0]       tag;

    logic [1:0]               rsp_valid, rsp_hit;
    logic [1:0][WID_W-1:0]    rsp_wid;
    logic [1:0][31:0]         rsp_instr;

    logic        lookup_en, flush_now, flush_pend, start_refill;
    logic [31:0] miss_line;
    logic        unused_pc;

    assign grant = {Grant2, Grant1};

    genvar s;
    generate
        for (s = 0; s < 2; s++) begin : g_slot
            icache_slot_lookup #(.NUM_WARP(NUM_WARP), .WID_W(WID_W)) u_slot (
                .grant  (grant[s]),
                .warp_pc(Warp_PC),
                .wid    (wid[s]),
                .pc     (pc[s]),
                .active (active[s])
            );
            assign off[s]   = pc[s][2 +: OB];
            assign idx[s]   = pc[s][2+OB +: IB];
            assign tag[s]   = pc[s][31 -: TW];
            assign hit[s]   = active[s] && valid_q[idx[s]] && (tag_q[idx[s]] == tag[s]);
            assign miss[s]  = active[s] && !hit[s];
            assign instr[s] = data_q[idx[s]][off[s]];
        end
    endgenerate

    assign unused_pc = ^{pc[0][1:0], pc[1][1:0]};

`ifdef ICACHE_FLUSH_EN
    // A flush seen while busy is deferred until the FSM is back in IDLE.
    assign flush_now = (state == S_IDLE) && (Icache_Flush || flush_pend);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flush_pend <= 1'b0;
        else        flush_pend <= (state != S_IDLE) && (flush_pend || Icache_Flush);
    end
`else
    assign flush_now  = 1'b0;
    assign flush_pend = 1'b0;
`endif

    assign lookup_en    = (state == S_IDLE) && !flush_now;
    assign start_refill = lookup_en && (|miss);
    // Slot 1 wins when both slots miss.
    assign miss_line    = miss[0] ? {pc[0][31:2+OB], {(2+OB){1'b0}}}
                                  : {pc[1][31:2+OB], {(2+OB){1'b0}}};

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (start_refill)  state_d = S_REQ;
            S_REQ:  if (Mem_Req_Ready) state_d = S_WAIT;
            S_WAIT: if (Mem_Rsp_Valid) state_d = S_FILL;
            S_FILL:                    state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            valid_q     <= '0;
            line_addr_q <= '0;
            rsp_valid   <= '0;
            rsp_hit     <= '0;
            rsp_wid     <= '0;
            rsp_instr   <= '0;
        end else begin
            state <= state_d;
            if (start_refill) line_addr_q <= miss_line;
            if (flush_now)
                valid_q <= '0;
            else if (state == S_FILL)
                valid_q[line_addr_q[2+OB +: IB]] <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                rsp_valid[i] <= active[i];
                rsp_hit[i]   <= lookup_en && hit[i];
                rsp_wid[i]   <= wid[i];
                rsp_instr[i] <= (lookup_en && hit[i]) ? instr[i] : 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_WAIT && Mem_Rsp_Valid) fill_data <= Mem_Rsp_Data;
        if (state == S_FILL) begin
            tag_q[line_addr_q[2+OB +: IB]]  <= line_addr_q[31 -: TW];
            data_q[line_addr_q[2+OB +: IB]] <= fill_data;
        end
    end

    assign Rsp1_Valid    = rsp_valid[0];
    assign Rsp1_Hit      = rsp_hit[0];
    assign Rsp1_Wid      = rsp_wid[0];
    assign Rsp1_Instr    = rsp_instr[0];
    assign Rsp2_Valid    = rsp_valid[1];
    assign Rsp2_Hit      = rsp_hit[1];
    assign Rsp2_Wid      = rsp_wid[1];
    assign Rsp2_Instr    = rsp_instr[1];
    assign Icache_Busy   = (state != S_IDLE) || flush_pend;
    assign Mem_Req_Valid = (state == S_REQ);
    assign Mem_Req_Addr  = line_addr_q;
endmodule

// File: tb/tb_icache_dual_fetch_responder.sv
// Directed bench for icache_dual_fetch_responder: cold miss, dual hit, busy drop,
// dual miss with eviction, reset mid-refill and (when enabled) flush.

module tb_icache_dual_fetch_responder;
    localparam int NW = 8;

    logic          clk = 0;
    logic          rst_n = 0;
    logic [NW-1:0] Grant1 = '0, Grant2 = '0;
    logic [NW*32-1:0] Warp_PC = '0;
    logic          Rsp1_Valid, Rsp1_Hit, Rsp2_Valid, Rsp2_Hit;
    logic [2:0]    Rsp1_Wid, Rsp2_Wid;
    logic [31:0]   Rsp1_Instr, Rsp2_Instr;
    logic          Icache_Busy, Mem_Req_Valid;
    logic [31:0]   Mem_Req_Addr;
    logic          Mem_Req_Ready = 0, Mem_Rsp_Valid = 0;
    logic [127:0]  Mem_Rsp_Data = '0;
`ifdef ICACHE_FLUSH_EN
    logic          Icache_Flush = 0;
`endif

    int total = 0;
    int bad = 0;

    localparam logic [127:0] LINE_A = {32'hAAAA0004, 32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001};
    localparam logic [127:0] LINE_B = {32'hBBBB0004, 32'hBBBB0003, 32'hBBBB0002, 32'hBBBB0001};
    localparam logic [127:0] LINE_C = {32'hCCCC0004, 32'hCCCC0003, 32'hCCCC0002, 32'hCCCC0001};

    icache_dual_fetch_responder dut (
        .clk(clk), .rst_n(rst_n),
`ifdef ICACHE_FLUSH_EN
        .Icache_Flush(Icache_Flush),
`endif
        .Grant1(Grant1), .Grant2(Grant2), .Warp_PC(Warp_PC),
        .Rsp1_Valid(Rsp1_Valid), .Rsp1_Hit(Rsp1_Hit), .Rsp1_Wid(Rsp1_Wid), .Rsp1_Instr(Rsp1_Instr),
        .Rsp2_Valid(Rsp2_Valid), .Rsp2_Hit(Rsp2_Hit), .Rsp2_Wid(Rsp2_Wid), .Rsp2_Instr(Rsp2_Instr),
        .Icache_Busy(Icache_Busy), .Mem_Req_Valid(Mem_Req_Valid), .Mem_Req_Addr(Mem_Req_Addr),
        .Mem_Req_Ready(Mem_Req_Ready), .Mem_Rsp_Valid(Mem_Rsp_Valid), .Mem_Rsp_Data(Mem_Rsp_Data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input int w, input logic [31:0] pc);
        Warp_PC[32*w +: 32] = pc;
    endtask

    // Drives a refill from REQ through WAIT and FILL back to IDLE.
    task automatic refill(input logic [127:0] line);
        Mem_Req_Ready = 1; tick(); Mem_Req_Ready = 0;
        Mem_Rsp_Valid = 1; Mem_Rsp_Data = line; tick(); Mem_Rsp_Valid = 0;
        tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        total++; if (Rsp1_Valid !== 1'b0) begin bad++; $display("FAIL reset_rsp1_valid got=%b want=0", Rsp1_Valid); end
        total++; if (Rsp2_Valid !== 1'b0) begin bad++; $display("FAIL reset_rsp2_valid got=%b want=0", Rsp2_Valid); end
        total++; if (Icache_Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Icache_Busy); end
        total++; if (Mem_Req_Valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b want=0", Mem_Req_Valid); end
        total++; if (Mem_Req_Addr !== 32'h0) begin bad++; $display("FAIL reset_req_addr got=%h want=0", Mem_Req_Addr); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_cold_miss();
        Grant1 = 8'b0000_0100; tick(); Grant1 = '0;
        total++; if ({Rsp1_Valid, Rsp1_Hit, Rsp1_Wid} !== {1'b1, 1'b0, 3'd2}) begin bad++; $display("FAIL cold_rsp1 got=%b%b%0d want=1,0,2", Rsp1_Valid, Rsp1_Hit, Rsp1_Wid); end
        total++; if (Rsp1_Instr !== 32'h0) begin bad++; $display("FAIL cold_instr got=%h want=0", Rsp1_Instr); end
        total++; if (Mem_Req_Valid !== 1'b1 || Mem_Req_Addr !== 32'h100) begin bad++; $display("FAIL cold_req got=%b/%h want=1/100", Mem_Req_Valid, Mem_Req_Addr); end
        tick();
        total++; if (Rsp1_Valid !== 1'b0) begin bad++; $display("FAIL cold_pulse got=%b want=0", Rsp1_Valid); end
        tick();
        total++; if (Mem_Req_Valid !== 1'b1 || Mem_Req_Addr !== 32'h100) begin bad++; $display("FAIL cold_req_hold got=%b/%h want=1/100", Mem_Req_Valid, Mem_Req_Addr); end
        Mem_Req_Ready = 1; tick(); Mem_Req_Ready = 0;
        total++; if (Mem_Req_Valid !== 1'b0 || Icache_Busy !== 1'b1) begin bad++; $display("FAIL cold_wait got=req%b busy%b want=req0 busy1", Mem_Req_Valid, Icache_Busy); end
        Mem_Rsp_Valid = 1; Mem_Rsp_Data = LINE_A; tick(); Mem_Rsp_Valid = 0;
        total++; if (Icache_Busy !== 1'b1) begin bad++; $display("FAIL cold_fill_busy got=%b want=1", Icache_Busy); end
        tick();
        total++; if (Icache_Busy !== 1'b0) begin bad++; $display("FAIL cold_idle_busy got=%b want=0", Icache_Busy); end
    endtask

    task automatic test_dual_hit();
        Grant1 = 8'b0000_0100; Grant2 = 8'b0010_0000; tick(); Grant1 = '0; Grant2 = '0;
        total++; if ({Rsp1_Valid, Rsp1_Hit, Rsp1_Wid} !== {1'b1, 1'b1, 3'd2}) begin bad++; $display("FAIL hit_rsp1 got=%b%b%0d want=1,1,2", Rsp1_Valid, Rsp1_Hit, Rsp1_Wid); end
        total++; if (Rsp1_Instr !== 32'hAAAA0001) begin bad++; $display("FAIL hit_instr1 got=%h want=aaaa0001", Rsp1_Instr); end
        total++; if ({Rsp2_Valid, Rsp2_Hit, Rsp2_Wid} !== {1'b1, 1'b1, 3'd5}) begin bad++; $display("FAIL hit_rsp2 got=%b%b%0d want=1,1,5", Rsp2_Valid, Rsp2_Hit, Rsp2_Wid); end
        total++; if (Rsp2_Instr !== 32'hAAAA0002) begin bad++; $display("FAIL hit_instr2 got=%h want=aaaa0002", Rsp2_Instr); end
        total++; if (Mem_Req_Valid !== 1'b0 || Icache_Busy !== 1'b0) begin bad++; $display("FAIL hit_no_req got=req%b busy%b want=0,0", Mem_Req_Valid, Icache_Busy); end
    endtask

    task automatic test_dual_miss_and_busy_drop();
        Grant1 = 8'b0000_0001; Grant2 = 8'b0000_0010; tick(); Grant1 = '0; Grant2 = '0;
        total++; if ({Rsp1_Valid, Rsp1_Hit, Rsp2_Valid, Rsp2_Hit} !== 4'b1010) begin bad++; $display("FAIL dmiss_rsp got=%b%b%b%b want=1010", Rsp1_Valid, Rsp1_Hit, Rsp2_Valid, Rsp2_Hit); end
        total++; if (Mem_Req_Valid !== 1'b1 || Mem_Req_Addr !== 32'h200) begin bad++; $display("FAIL dmiss_req got=%b/%h want=1/200", Mem_Req_Valid, Mem_Req_Addr); end
        Mem_Req_Ready = 1; tick(); Mem_Req_Ready = 0;
        // In WAIT: a grant is dropped as a retry and the FSM does not move.
        Grant1 = 8'b1000_0000; tick(); Grant1 = '0;
        total++; if ({Rsp1_Valid, Rsp1_Hit, Rsp1_Wid} !== {1'b1, 1'b0, 3'd7}) begin bad++; $display("FAIL busy_drop got=%b%b%0d want=1,0,7", Rsp1_Valid, Rsp1_Hit, Rsp1_Wid); end
        total++; if (Icache_Busy !== 1'b1 || Mem_Req_Valid !== 1'b0) begin bad++; $display("FAIL busy_state got=busy%b req%b want=1,0", Icache_Busy, Mem_Req_Valid); end
        Mem_Rsp_Valid = 1; Mem_Rsp_Data = LINE_B; tick(); Mem_Rsp_Valid = 0;
        tick(); tick();
        total++; if (Icache_Busy !== 1'b0 || Mem_Req_Valid !== 1'b0) begin bad++; $display("FAIL dmiss_one_req got=busy%b req%b want=0,0", Icache_Busy, Mem_Req_Valid); end
        set_pc(0, 32'h208);
        Grant1 = 8'b0000_0001; tick(); Grant1 = '0;
        total++; if (Rsp1_Hit !== 1'b1 || Rsp1_Instr !== 32'hBBBB0003) begin bad++; $display("FAIL dmiss_fill_hit got=%b/%h want=1/bbbb0003", Rsp1_Hit, Rsp1_Instr); end
        tick();
    endtask

    task automatic test_reset_mid_refill();
        // 0x100 shares index 0 with 0x200 and was evicted.
        Grant1 = 8'b0000_0100; tick(); Grant1 = '0;
        total++; if (Rsp1_Hit !== 1'b0 || Mem_Req_Addr !== 32'h100) begin bad++; $display("FAIL evict got=hit%b addr%h want=0/100", Rsp1_Hit, Mem_Req_Addr); end
        Mem_Req_Ready = 1; tick(); Mem_Req_Ready = 0;
        rst_n = 0; #1;
        total++; if (Icache_Busy !== 1'b0 || Mem_Req_Valid !== 1'b0) begin bad++; $display("FAIL rst_mid got=busy%b req%b want=0,0", Icache_Busy, Mem_Req_Valid); end
        tick(); rst_n = 1;
        Mem_Rsp_Valid = 1; Mem_Rsp_Data = LINE_C; tick(); Mem_Rsp_Valid = 0;
        tick();
        total++; if (Icache_Busy !== 1'b0) begin bad++; $display("FAIL late_rsp_busy got=%b want=0", Icache_Busy); end
        Grant2 = 8'b0000_1000; tick(); Grant2 = '0;
        total++; if ({Rsp2_Valid, Rsp2_Hit, Rsp2_Wid} !== {1'b1, 1'b0, 3'd3}) begin bad++; $display("FAIL rst_miss got=%b%b%0d want=1,0,3", Rsp2_Valid, Rsp2_Hit, Rsp2_Wid); end
        total++; if (Mem_Req_Valid !== 1'b1 || Mem_Req_Addr !== 32'h100) begin bad++; $display("FAIL rst_req got=%b/%h want=1/100", Mem_Req_Valid, Mem_Req_Addr); end
        refill(LINE_A);
        set_pc(7, 32'h10C);
        Grant2 = 8'b1000_0000; tick(); Grant2 = '0;
        total++; if (Rsp2_Hit !== 1'b1 || Rsp2_Instr !== 32'hAAAA0004) begin bad++; $display("FAIL refill_word3 got=%b/%h want=1/aaaa0004", Rsp2_Hit, Rsp2_Instr); end
        tick();
    endtask

`ifdef ICACHE_FLUSH_EN
    task automatic test_flush();
        Icache_Flush = 1; tick(); Icache_Flush = 0;
        Grant1 = 8'b0000_0100; tick(); Grant1 = '0;
        total++; if (Rsp1_Valid !== 1'b1 || Rsp1_Hit !== 1'b0) begin bad++; $display("FAIL flush_miss got=%b%b want=10", Rsp1_Valid, Rsp1_Hit); end
        total++; if (Mem_Req_Valid !== 1'b1 || Mem_Req_Addr !== 32'h100) begin bad++; $display("FAIL flush_req got=%b/%h want=1/100", Mem_Req_Valid, Mem_Req_Addr); end
        refill(LINE_A);
    endtask
`endif

    initial begin
        set_pc(2, 32'h100);
        set_pc(5, 32'h104);
        set_pc(0, 32'h200);
        set_pc(1, 32'h300);
        set_pc(7, 32'h104);
        set_pc(3, 32'h100);
        test_reset();
        test_cold_miss();
        test_dual_hit();
        test_dual_miss_and_busy_drop();
        test_reset_mid_refill();
`ifdef ICACHE_FLUSH_EN
        test_flush();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
